// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single combinational memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data priority.
module mem_arbiter #(
    parameter int ADDR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sample;
    logic        sel_d;
    logic        win_d;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // On contention the port that did not win last time goes first.
    always_comb begin
        sel_d = d_req && (!if_req || !last_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (sample) begin
            last_d <= sel_d;
        end
    end
`else
    always_comb begin
        sel_d = d_req;
    end
`endif

    assign sample = (state != ACCESS) && (if_req || d_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RESP: state_nxt = (if_req || d_req) ? ACCESS : IDLE;
            ACCESS:     state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        unique case (state)
            ACCESS: begin
                if_gnt       = !win_d;
                d_gnt        = win_d;
                mem_memwrite = lat_we;
                mem_memread  = !lat_we;
            end
            RESP: begin
                if_rvalid = !win_d;
                d_rvalid  = win_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (sample) begin
            win_d     <= sel_d;
            lat_we    <= sel_d && d_we;
            lat_addr  <= sel_d ? d_addr : if_addr;
            lat_wdata <= sel_d ? d_wdata : 32'h0;
        end
    end

    // Read data is captured at the end of ACCESS and held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == ACCESS && !lat_we) begin
            if (win_d) begin
                d_rdata_q <= mem_read_data;
            end else begin
                if_rdata_q <= mem_read_data;
            end
        end
    end

    assign mem_addr       = lat_addr >> ADDR_SHIFT;
    assign mem_write_data = lat_wdata;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;

endmodule
